// File: rtl/serial_paralelo_if.sv
// Serial-to-parallel receive bus: one serial bit in, aligned symbols plus status out.
interface serial_paralelo_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       sym_strobe;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  sym_strobe
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output sym_strobe
    );
endinterface

// File: rtl/serial_paralelo.sv
// Receive deserializer: bit-granular hunt for COM, confirm with COM_COUNT aligned COMs,
// then emit one registered symbol every 8 bit clocks. Lock is held until reset.
module serial_paralelo #(
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter int         COM_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    serial_paralelo_if.slave bus
);
    localparam logic [3:0] COM_COUNT_W = 4'(COM_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state_r,      state_nxt_s;
    logic [7:0] sr_r;
    logic [2:0] bc_r,         bc_nxt_s;
    logic [3:0] com_cnt_r,    com_cnt_nxt_s;
    logic [7:0] data_out_r,   data_out_nxt_s;
    logic       valid_out_r,  valid_out_nxt_s;
    logic       active_r,     active_nxt_s;
    logic       sym_strobe_r, sym_strobe_nxt_s;
    logic [7:0] nxt_s;
    logic       boundary_s;
    logic       is_com_s;

    assign nxt_s      = {sr_r[6:0], bus.data_in};
    assign boundary_s = (bc_r == 3'd7);
    assign is_com_s   = (nxt_s == COM_SYM);

    // Next-state and output decode for the alignment FSM
    always_comb begin
        state_nxt_s      = state_r;
        bc_nxt_s         = bc_r + 3'd1;
        com_cnt_nxt_s    = com_cnt_r;
        data_out_nxt_s   = data_out_r;
        valid_out_nxt_s  = valid_out_r;
        active_nxt_s     = active_r;
        sym_strobe_nxt_s = 1'b0;

        case (state_r)
            SEARCH: begin
                if (is_com_s) begin
                    bc_nxt_s      = 3'd0;
                    com_cnt_nxt_s = 4'd1;
                    state_nxt_s   = ALIGN;
                end else begin
                    com_cnt_nxt_s = 4'd0;
                end
            end
            ALIGN: begin
                if (boundary_s) begin
                    if (is_com_s) begin
                        // Saturate rather than wrap so a long idle run can never look short
                        com_cnt_nxt_s = (com_cnt_r == COM_COUNT_W) ? com_cnt_r : com_cnt_r + 4'd1;
                        if ((com_cnt_r + 4'd1) == COM_COUNT_W) begin
                            state_nxt_s  = ACTIVE;
                            active_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s  = ALIGN;
                        end
                    end else begin
                        state_nxt_s   = SEARCH;
                        com_cnt_nxt_s = 4'd0;
                    end
                end else begin
                    state_nxt_s = ALIGN;
                end
            end
            ACTIVE: begin
                if (boundary_s) begin
                    data_out_nxt_s   = nxt_s;
                    valid_out_nxt_s  = !is_com_s;
                    sym_strobe_nxt_s = 1'b1;
                end else begin
                    sym_strobe_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s   = SEARCH;
                com_cnt_nxt_s = 4'd0;
                active_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, shift register, counters and registered outputs
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_r      <= SEARCH;
            sr_r         <= 8'h00;
            bc_r         <= 3'd0;
            com_cnt_r    <= 4'd0;
            data_out_r   <= 8'h00;
            valid_out_r  <= 1'b0;
            active_r     <= 1'b0;
            sym_strobe_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sr_r         <= nxt_s;
            bc_r         <= bc_nxt_s;
            com_cnt_r    <= com_cnt_nxt_s;
            data_out_r   <= data_out_nxt_s;
            valid_out_r  <= valid_out_nxt_s;
            active_r     <= active_nxt_s;
            sym_strobe_r <= sym_strobe_nxt_s;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.valid_out  = valid_out_r;
    assign bus.active     = active_r;
    assign bus.sym_strobe = sym_strobe_r;
endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: reset, lock, rejected lock, data path, mid-symbol reset, loopback.
module tb_serial_paralelo;
    logic clk_32f = 1'b0;
    logic reset;

    serial_paralelo_if bus();

    serial_paralelo #(.COM_SYM(8'hBC), .COM_COUNT(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    // Bit clock
    always #5 clk_32f = ~clk_32f;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         strobe_cnt;
    int         strobe_total;
    logic [7:0] mid_data;
    logic       collect;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] b;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive one bit, let one edge pass, sample 1 time unit later
    task automatic send_bit(input logic v);
        bus.data_in = v;
        @(posedge clk_32f);
        #1;
        if (bus.sym_strobe) begin
            strobe_cnt++;
            if (collect && bus.valid_out) got_q.push_back(bus.data_out);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        strobe_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (i == 4) mid_data = bus.data_out;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        bus.data_in = 1'b0;
        collect     = 1'b0;

        // 1: reset held with random stimulus
        repeat (64) begin
            bus.data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
        end
        chk("rst_data",   bus.data_out, 8'h00);
        chk("rst_valid",  {7'd0, bus.valid_out}, 8'h00);
        chk("rst_active", {7'd0, bus.active}, 8'h00);
        chk("rst_strobe", {7'd0, bus.sym_strobe}, 8'h00);

        // 2: junk bits, 4x COM, then 0x55
        reset = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (3) send_byte(8'hBC);
        chk("t2_active_pre", {7'd0, bus.active}, 8'h00);
        send_byte(8'hBC);
        chk("t2_active_lock", {7'd0, bus.active}, 8'h01);
        chk("t2_lock_strobe", {7'd0, bus.sym_strobe}, 8'h00);
        chk("t2_lock_data",   bus.data_out, 8'h00);
        chk("t2_lock_valid",  {7'd0, bus.valid_out}, 8'h00);
        send_byte(8'h55);
        chk("t2_data",       bus.data_out, 8'h55);
        chk("t2_valid",      {7'd0, bus.valid_out}, 8'h01);
        chk("t2_strobe",     {7'd0, bus.sym_strobe}, 8'h01);
        chk("t2_strobe_cnt", 8'(strobe_cnt), 8'h01);

        // 3: interrupted COM run, then a full run
        pulse_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h12);
        chk("t3_active_12", {7'd0, bus.active}, 8'h00);
        repeat (3) send_byte(8'hBC);
        chk("t3_active_3bc", {7'd0, bus.active}, 8'h00);
        send_byte(8'hBC);
        chk("t3_active_4bc", {7'd0, bus.active}, 8'h01);
        send_byte(8'h77);
        chk("t3_data",       bus.data_out, 8'h77);
        chk("t3_valid",      {7'd0, bus.valid_out}, 8'h01);
        chk("t3_strobe_cnt", 8'(strobe_cnt), 8'h01);

        // 4: locked data path, including a COM idle
        send_byte(8'hA1);
        chk("t4_hold_77", mid_data, 8'h77);
        chk("t4_a1_data", bus.data_out, 8'hA1);
        chk("t4_a1_valid", {7'd0, bus.valid_out}, 8'h01);
        chk("t4_a1_stb", 8'(strobe_cnt), 8'h01);
        send_byte(8'hBC);
        chk("t4_hold_a1", mid_data, 8'hA1);
        chk("t4_bc_data", bus.data_out, 8'hBC);
        chk("t4_bc_valid", {7'd0, bus.valid_out}, 8'h00);
        chk("t4_bc_stb", 8'(strobe_cnt), 8'h01);
        send_byte(8'h3F);
        chk("t4_hold_bc", mid_data, 8'hBC);
        chk("t4_3f_data", bus.data_out, 8'h3F);
        chk("t4_3f_valid", {7'd0, bus.valid_out}, 8'h01);
        chk("t4_3f_stb", 8'(strobe_cnt), 8'h01);

        // 5: reset mid-symbol, then a short COM run must not lock
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_data",   bus.data_out, 8'h00);
        chk("t5_valid",  {7'd0, bus.valid_out}, 8'h00);
        chk("t5_active", {7'd0, bus.active}, 8'h00);
        repeat (3) @(posedge clk_32f);
        #1;
        reset = 1'b1;
        strobe_total = 0;
        repeat (3) begin
            send_byte(8'hBC);
            strobe_total += strobe_cnt;
        end
        send_byte(8'h10);
        strobe_total += strobe_cnt;
        chk("t5_no_lock",   {7'd0, bus.active}, 8'h00);
        chk("t5_no_strobe", 8'(strobe_total), 8'h00);

        // 6: serialized stream of random data bytes mixed with idles
        pulse_reset();
        repeat (4) send_byte(8'hBC);
        chk("t6_lock", {7'd0, bus.active}, 8'h01);
        collect = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'hBC;
            end else begin
                b = 8'($urandom_range(0, 255));
                while (b == 8'hBC) b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
            end
            send_byte(b);
            chk("t6_strobe", 8'(strobe_cnt), 8'h01);
        end
        collect = 1'b0;
        chk("t6_count", 8'(got_q.size()), 8'(exp_q.size()));
        for (int n = 0; n < exp_q.size(); n++) begin
            if (n < got_q.size()) chk("t6_byte", got_q[n], exp_q[n]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
